bin2bcd_seq: RTL and testbench

- Iterative, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
- Generalises the fixed 16-bit / 4-digit divider chain to any input width and digit count.
- Adds a start/busy/done handshake, an overflow flag with saturation, and optional leading-zero blanking.
- Sits between counter/UART receive data and the 7-segment display driver; one conversion in flight at a time.

---
 rtl/bin2bcd_pkg.sv | 24 ++
 rtl/bcd_dabble_digit.sv | 28 ++
 rtl/bin2bcd_seq.sv | 174 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and constants for the iterative binary-to-BCD converter.
//   state_t        : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W    : width of one BCD digit
//   BCD_ADJ_THRESH : digit value at or above which the add-3 correction applies
//   BCD_ADJ_ADD    : correction added before each shift
//   BCD_NINE       : per-digit saturation value used on overflow
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE       = 4'h9;

endpackage : bin2bcd_pkg

// File: rtl/bcd_dabble_digit.sv
// -----------------------------------------------------------------------------
// bcd_dabble_digit
// Purely combinational shift-and-add-3 correction for one BCD digit.
// A digit of 5 or more becomes >= 8 after adding 3, so the following left
// shift carries a decimal ten into the next digit.
// Ports:
//   digit_in  : current BCD digit from the accumulator
//   digit_adj : digit after the conditional add-3 (4-bit, wraps, no carry out)
//   msb_out   : bit 3 of digit_adj; the bit shifted into the next digit
// -----------------------------------------------------------------------------
module bcd_dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_adj,
    output logic                   msb_out
);

    always_comb begin
        digit_adj = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) begin
            digit_adj = digit_in + BCD_ADJ_ADD;
        end
    end

    assign msb_out = digit_adj[BCD_DIGIT_W-1];

endmodule : bcd_dabble_digit

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// One conversion in flight at a time.
//
// Parameters:
//   BIN_W  : binary operand width (>= 4)
//   DIGITS : number of BCD output digits (>= 1)
//   CNT_W  : shift counter width, derived from BIN_W
//
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : conversion request, only looked at while idle
//   bin_in  : binary operand, captured on an accepted start
//   busy    : conversion in progress (shift phase)
//   done    : one-cycle pulse; bcd_out/ovf (and blank) valid from this cycle
//   bcd_out : packed BCD result, digit k at [4k+3:4k], digit 0 = units
//   ovf     : operand exceeded 10^DIGITS-1; bcd_out saturated to all 9s
//   blank   : leading-zero mask, present only with BIN2BCD_BLANK_EN defined
//
// Handshake: start is a request sampled on a rising edge while the FSM is
// idle; it is accepted on that edge (bin_in captured) and busy rises in the
// next cycle. Requests while a conversion runs are dropped, not queued.
// Completion is signalled by a single-cycle done pulse with busy already low;
// results stay stable until the next completion.
//
// Optional feature macro: BIN2BCD_BLANK_EN adds the blank output.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]             blank
`endif
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

    if (BIN_W < 4) begin : g_bin_w_chk
        $error("bin2bcd_seq: BIN_W must be at least 4");
    end
    if (DIGITS < 1) begin : g_digits_chk
        $error("bin2bcd_seq: DIGITS must be at least 1");
    end

    state_t           state;
    logic [BIN_W-1:0] sr;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic [CNT_W-1:0] cnt;

    logic [DIGITS-1:0] msb;
    logic [ACC_W-1:0]  acc_shift;

    // Adjust every digit, then shift the whole {acc, sr} chain left by one.
    // Each digit's post-adjust MSB becomes the LSB of the digit above; the
    // binary MSB feeds digit 0. The top digit's MSB would fall off the end,
    // which is exactly the condition for the value not fitting in DIGITS.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [BCD_DIGIT_W-1:0] d_adj;
        logic                   cin;

        bcd_dabble_digit u_cell (
            .digit_in  (acc[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .digit_adj (d_adj),
            .msb_out   (msb[k])
        );

        if (k == 0) begin : g_lsd
            assign cin = sr[BIN_W-1];
        end else begin : g_upper
            assign cin = msb[k-1];
        end

        assign acc_shift[BCD_DIGIT_W*k +: BCD_DIGIT_W] =
            (d_adj << 1) | {{(BCD_DIGIT_W-1){1'b0}}, cin};
    end

`ifdef BIN2BCD_BLANK_EN
    // A digit is blanked when it and every digit above it are zero. The
    // units digit always shows so a zero result reads "0"; a saturated
    // result is never blanked.
    logic [DIGITS-1:0] blank_next;
    logic              zero_run;

    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run & (acc[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
            blank_next[k] = zero_run;
        end
        blank_next[0] = 1'b0;
        if (ovf_acc) begin
            blank_next = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr      <= bin_in;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= {sr[BIN_W-2:0], 1'b0};
                    acc <= acc_shift;
                    if (msb[DIGITS-1]) begin
                        ovf_acc <= 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                    // busy drops with the last shift so it is already low
                    // when the done pulse appears.
                    if (cnt == LAST_CNT) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_out <= ovf_acc ? ALL_NINES : acc;
                    ovf     <= ovf_acc;
`ifdef BIN2BCD_BLANK_EN
                    blank   <= blank_next;
`endif
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq. Three instances share clock/reset:
//   u0 : defaults (BIN_W=16, DIGITS=5)
//   u1 : BIN_W=16, DIGITS=4 (overflow / saturation)
//   u2 : BIN_W=8,  DIGITS=3 (back-to-back sweep with start held high)
// Expected results come from a decimal arithmetic model (mod/div by 10).
// Optional blank checks follow BIN2BCD_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;

    logic        start0, start1, start2;
    logic [15:0] bin0, bin1;
    logic [7:0]  bin2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;
    logic        ovf0, ovf1, ovf2;
`ifdef BIN2BCD_BLANK_EN
    logic [4:0]  blank0;
    logic [3:0]  blank1;
    logic [2:0]  blank2;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp [2];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    bin2bcd_seq u0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start0),
        .bin_in  (bin0),
        .busy    (busy0),
        .done    (done0),
        .bcd_out (bcd0),
        .ovf     (ovf0)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank   (blank0)
`endif
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .bin_in  (bin1),
        .busy    (busy1),
        .done    (done1),
        .bcd_out (bcd1),
        .ovf     (ovf1)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank   (blank1)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .bin_in  (bin2),
        .busy    (busy2),
        .done    (done2),
        .bcd_out (bcd2),
        .ovf     (ovf2)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank   (blank2)
`endif
    );

    // ---------------- reference model ----------------
    function automatic bit ref_ovf(input int unsigned v, input int digits);
        int unsigned lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        return (v >= lim);
    endfunction

    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] r = '0;
        int unsigned x = v;
        for (int k = 0; k < digits; k++) begin
            if (ref_ovf(v, digits)) begin
                r[4*k +: 4] = 4'd9;
            end else begin
                r[4*k +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_blank(input int unsigned v, input int digits);
        logic [31:0] r = '0;
        int nd = 1;
        int unsigned x = v / 10;
        if (ref_ovf(v, digits)) return '0;
        while (x != 0) begin
            nd++;
            x = x / 10;
        end
        for (int k = nd; k < digits; k++) r[k] = 1'b1;
        return r;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic set_start(input int unit, input logic s, input logic [15:0] b);
        if (unit == 0) begin
            start0 = s;
            bin0   = b;
        end else begin
            start1 = s;
            bin1   = b;
        end
    endtask

    function automatic logic [31:0] cur_bcd(input int unit);
        return (unit == 0) ? {12'd0, bcd0} : {16'd0, bcd1};
    endfunction

    function automatic logic cur_busy(input int unit);
        return (unit == 0) ? busy0 : busy1;
    endfunction

    function automatic logic cur_done(input int unit);
        return (unit == 0) ? done0 : done1;
    endfunction

    function automatic logic cur_ovf(input int unit);
        return (unit == 0) ? ovf0 : ovf1;
    endfunction

`ifdef BIN2BCD_BLANK_EN
    function automatic logic [31:0] cur_blank(input int unit);
        return (unit == 0) ? {27'd0, blank0} : {28'd0, blank1};
    endfunction
`endif

    // One full conversion on u0 or u1. Optionally re-pulses start mid-flight
    // and scrambles bin_in after capture; neither may disturb the result.
    task automatic conv(input int unit, input int unsigned v, input bit pulse);
        int          digits = (unit == 0) ? 5 : 4;
        int          lat    = -1;
        int          busy_n = 0;
        int          extra  = 0;
        logic [31:0] prev   = last_exp[unit];
        logic [31:0] exp_b  = ref_bcd(v, digits);
        logic [15:0] junk   = 16'(v) ^ 16'h5a5a;

        @(negedge clk);
        set_start(unit, 1'b1, 16'(v));
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            set_start(unit, pulse && (i == 3 || i == 10), junk);
            if (cur_done(unit)) begin
                lat = i - 1;
                break;
            end
            if (cur_busy(unit)) busy_n++;
            if (i == 5) check("hold_prev_bcd", cur_bcd(unit), prev);
        end
        set_start(unit, 1'b0, junk);
        check("latency_edges", lat, 17);
        check("busy_cycles", busy_n, 16);
        check("busy_at_done", {31'd0, cur_busy(unit)}, 32'd0);
        check("bcd_out", cur_bcd(unit), exp_b);
        check("ovf", {31'd0, cur_ovf(unit)}, {31'd0, ref_ovf(v, digits)});
`ifdef BIN2BCD_BLANK_EN
        check("blank", cur_blank(unit), ref_blank(v, digits));
`endif
        last_exp[unit] = exp_b;
        @(negedge clk);
        check("done_single_pulse", {31'd0, cur_done(unit)}, 32'd0);
        if (pulse) begin
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (cur_done(unit)) extra++;
            end
            check("no_extra_done", extra, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] exp_q [$];

    initial begin
        int ndone;
        int gap;
        int nxt;
        int extra;
        logic [7:0] v8;

        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bin0   = '0;   bin1   = '0;   bin2   = '0;
        last_exp[0] = '0;
        last_exp[1] = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_bcd", {12'd0, bcd0}, 32'd0);
        check("rst_ovf", {31'd0, ovf0}, 32'd0);
        check("rst_bcd_u1", {16'd0, bcd1}, 32'd0);
        check("rst_bcd_u2", {20'd0, bcd2}, 32'd0);
`ifdef BIN2BCD_BLANK_EN
        check("rst_blank", {27'd0, blank0}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // directed conversions on defaults
        conv(0, 1234, 1'b0);
        conv(0, 65535, 1'b0);
        conv(0, 0, 1'b0);
        conv(0, 42, 1'b1);
        conv(0, 99999 % 65536, 1'b0);
        repeat (6) conv(0, $urandom_range(0, 65535), 1'b0);

        // four digits: saturation boundary
        conv(1, 9999, 1'b0);
        conv(1, 10000, 1'b0);
        conv(1, 0, 1'b0);
        repeat (6) conv(1, $urandom_range(0, 65535), 1'b0);
        repeat (3) conv(1, $urandom_range(0, 9999), 1'b0);

        // reset while converting: abandoned, no done, outputs cleared
        @(negedge clk);
        start0 = 1'b1;
        bin0   = 16'd500;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_done", {31'd0, done0}, 32'd0);
        check("midrst_bcd", {12'd0, bcd0}, 32'd0);
        check("midrst_ovf", {31'd0, ovf0}, 32'd0);
`ifdef BIN2BCD_BLANK_EN
        check("midrst_blank", {27'd0, blank0}, 32'd0);
`endif
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done0) extra++;
        end
        check("midrst_no_done", extra, 0);
        last_exp[0] = '0;
        last_exp[1] = '0;

        // 8-bit sweep, start held high: one result every BIN_W+2 = 10 cycles
        @(negedge clk);
        start2 = 1'b1;
        bin2   = 8'd0;
        exp_q.push_back(8'd0);
        nxt   = 1;
        ndone = 0;
        gap   = 0;
        while (ndone < 256) begin
            @(negedge clk);
            gap++;
            if (done2) begin
                v8 = exp_q.pop_front();
                check("sweep_gap", gap, 10);
                check("sweep_bcd", {20'd0, bcd2}, ref_bcd(v8, 3));
                check("sweep_ovf", {31'd0, ovf2}, 32'd0);
`ifdef BIN2BCD_BLANK_EN
                check("sweep_blank", {29'd0, blank2}, ref_blank(v8, 3));
`endif
                ndone++;
                gap = 0;
                if (nxt < 256) begin
                    bin2 = 8'(nxt);
                    exp_q.push_back(8'(nxt));
                    nxt++;
                end else begin
                    start2 = 1'b0;
                end
            end else if (gap > 40) begin
                check("sweep_timeout", 32'd1, 32'd0);
                break;
            end
        end
        start2 = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bin2bcd_seq
